life_snapshot_reader: RTL and testbench
=======================================

LIFE_SNAPSHOT_READER -- requirements
Module: life_snapshot_reader

Interface
REQ-001 Parameter N_CELLS, default 64, cells per serial column ring; the block SHALL support only the value 64.
REQ-002 Parameter CNT_W, default 6, width of the cell index, equal to log2(N_CELLS).
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge, except on reset.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cell_in  input  1  serial cell state, driven from the column ring data_out.
REQ-006 cnt_in  input  CNT_W  column ring index of cell_in in the current cycle.
REQ-007 capture_req  input  1  single-cycle request to capture one full generation.
REQ-008 snap_ready  input  1  consumer accepts the snapshot.
REQ-009 clear_err  input  1  clears the sticky error flags.
REQ-010 snap_valid  output  1  snapshot available.
REQ-011 snap_data  output  N_CELLS  captured cells, bit k = cell sampled when cnt_in==k.
REQ-012 snap_pop  output  CNT_W+1  count of live cells in snap_data, range 0..64.
REQ-013 busy  output  1  high in ARM and SHIFT.
REQ-014 overrun  output  1  sticky: a capture_req arrived while not IDLE.
REQ-015 seq_err  output  1  sticky: cnt_in discontinuity during SHIFT.

Function
REQ-016 FSM states SHALL be IDLE, ARM, SHIFT and HOLD; reset enters IDLE.
REQ-017 IDLE: capture_req=1 -> ARM; otherwise stay.
REQ-018 ARM: in the cycle cnt_in==0, sample cell_in into bit 0, load pop with cell_in, -> SHIFT; otherwise stay, with no limit on wait time.
REQ-019 SHIFT: each cycle sample cell_in into bit cnt_in and add cell_in to pop.
REQ-020 SHIFT, cnt_in==63 sampled: -> HOLD; snap_valid rises the next cycle (65 cycles after the cnt_in==0 sample cycle, counting that cycle as 1).
REQ-021 SHIFT: if cnt_in != previous cnt_in+1 (mod 64), set seq_err, discard the partial capture, -> IDLE; snap_valid stays 0.
REQ-022 HOLD: snap_valid=1; snap_data and snap_pop stay stable until snap_valid & snap_ready.
REQ-023 HOLD with snap_ready=1: handshake completes that cycle; -> IDLE, and snap_valid=0 the next cycle.
REQ-024 HOLD with snap_ready=1 and capture_req=1 in the same cycle: the request is accepted, -> ARM directly, and overrun is not set.
REQ-025 capture_req in ARM, SHIFT, or HOLD without handshake: ignored, overrun set.
REQ-026 snap_data/snap_pop SHALL update only in HOLD entry; partial captures never appear on the outputs.
REQ-027 snap_pop accumulator SHALL be CNT_W+1 bits and never wrap; 64 live cells -> 7'd64.
REQ-028 clear_err=1 clears overrun and seq_err; a set event in the same cycle wins, so the flag stays 1.
REQ-029 snap_ready outside HOLD SHALL have no effect.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE, snap_valid=0, snap_data=0, snap_pop=0, busy=0, overrun=0, seq_err=0.
REQ-031 Reset mid-SHIFT or mid-HOLD SHALL discard the capture; after release the block SHALL wait for a new capture_req.
REQ-032 No output SHALL be X after reset assertion.

Structure
REQ-033 A shared life package SHALL hold N_CELLS, CNT_W and the FSM state encoding, shared with the column ring and the seed loader.
REQ-034 One sub-module SHALL be used: life_bit_deserializer (index-addressed bit capture plus pop accumulator); the FSM and flags stay in the top.
REQ-035 Target size is 120-400 lines of RTL; no memories, flops only.

Verification
REQ-036 Pattern 0xAAAA_AAAA_AAAA_AAAA on the ring, capture_req at cnt=10 -> wait to cnt=0; snap_valid 65 cycles after the cnt=0 sample cycle; snap_data=0xAAAA_AAAA_AAAA_AAAA; snap_pop=32.
REQ-037 All-ones ring, then all-zeros ring -> snap_pop=64 then 0, no wrap; snap_data all-ones then 0.
REQ-038 snap_ready held low 20 cycles, with capture_req pulsed in HOLD -> data stable, overrun=1; clear_err -> overrun=0.
REQ-039 cnt_in jump 17->19 in SHIFT -> seq_err=1, IDLE, snap_valid never asserted; the next capture is good.
REQ-040 rst_n low at SHIFT index 30 -> all outputs 0 at once; after release, stay IDLE until capture_req.
REQ-041 snap_ready=1 and capture_req=1 in the same HOLD cycle -> ARM, overrun=0, second snapshot correct.

Source files
------------

// File: rtl/life_snapshot_reader_pkg.sv
// Shared life constants and snapshot-reader FSM encoding, used by the column ring,
// the seed loader and the snapshot reader.
package life_snapshot_reader_pkg;

    localparam int N_CELLS = 64;
    localparam int CNT_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } life_state_t;

endpackage

// File: rtl/life_snapshot_reader_if.sv
// Ring-side, control and snapshot signals of the snapshot reader.
// The slave side is the reader; the master side is the ring/consumer environment.
interface life_snapshot_reader_if;
    import life_snapshot_reader_pkg::*;

    logic               cell_in;
    logic [CNT_W-1:0]   cnt_in;
    logic               capture_req;
    logic               snap_ready;
    logic               clear_err;
    logic               snap_valid;
    logic [N_CELLS-1:0] snap_data;
    logic [CNT_W:0]     snap_pop;
    logic               busy;
    logic               overrun;
    logic               seq_err;

    modport master (
        output cell_in, cnt_in, capture_req, snap_ready, clear_err,
        input  snap_valid, snap_data, snap_pop, busy, overrun, seq_err
    );

    modport slave (
        input  cell_in, cnt_in, capture_req, snap_ready, clear_err,
        output snap_valid, snap_data, snap_pop, busy, overrun, seq_err
    );

endinterface

// File: rtl/life_bit_deserializer.sv
// Index-addressed serial-to-parallel capture with a live-cell count.
// Latency: result registers load on the commit cycle, including that cycle's bit.
// No backpressure: the owner decides when to start, shift and commit.
module life_bit_deserializer #(
    parameter int N_CELLS = 64,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               shift,
    input  logic               commit,
    input  logic               bit_in,
    input  logic [CNT_W-1:0]   idx,
    output logic [N_CELLS-1:0] snap_data,
    output logic [CNT_W:0]     snap_pop
);

    logic [N_CELLS-1:0] acc_data;
    logic [N_CELLS-1:0] acc_next;
    logic [CNT_W:0]     acc_pop;
    logic [CNT_W:0]     pop_next;

    always_comb begin
        acc_next      = acc_data;
        acc_next[idx] = bit_in;
    end

    // One extra count bit so a fully live ring reads 64 instead of wrapping to 0.
    assign pop_next = (start ? '0 : acc_pop) + (CNT_W+1)'(bit_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data  <= '0;
            acc_pop   <= '0;
            snap_data <= '0;
            snap_pop  <= '0;
        end else begin
            if (start || shift) begin
                acc_data <= acc_next;
                acc_pop  <= pop_next;
            end
            if (commit) begin
                snap_data <= acc_next;
                snap_pop  <= pop_next;
            end
        end
    end

endmodule

// File: rtl/life_snapshot_reader.sv
// Captures one full generation from a serial column ring into a parallel snapshot.
// Latency: snap_valid rises 65 cycles after the cnt_in==0 sample cycle (inclusive).
// Backpressure: snapshot held stable until snap_valid & snap_ready; extra requests flag overrun.
module life_snapshot_reader #(
    parameter int N_CELLS = 64,
    parameter int CNT_W   = 6
) (
    input logic                   clk,
    input logic                   rst_n,
    life_snapshot_reader_if.slave bus
);
    import life_snapshot_reader_pkg::life_state_t;
    import life_snapshot_reader_pkg::ST_IDLE;
    import life_snapshot_reader_pkg::ST_ARM;
    import life_snapshot_reader_pkg::ST_SHIFT;
    import life_snapshot_reader_pkg::ST_HOLD;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_CELLS - 1);

    life_state_t      state;
    logic [CNT_W-1:0] last_cnt;
    logic             snap_valid_q;
    logic             busy_q;
    logic             overrun_q;
    logic             seq_err_q;

    logic at_zero;
    logic at_last;
    logic in_seq;
    logic start;
    logic shift;
    logic commit;
    logic handshake;
    logic ovr_set;
    logic seq_set;

    assign at_zero   = (bus.cnt_in == '0);
    assign at_last   = (bus.cnt_in == LAST_IDX);
    assign in_seq    = (bus.cnt_in == CNT_W'(last_cnt + 1'b1));
    assign start     = (state == ST_ARM) && at_zero;
    assign shift     = (state == ST_SHIFT) && in_seq;
    assign commit    = shift && at_last;
    assign handshake = (state == ST_HOLD) && bus.snap_ready;
    // A request landing on the handshake cycle is a legitimate back-to-back capture.
    assign ovr_set   = bus.capture_req && (state != ST_IDLE) && !handshake;
    assign seq_set   = (state == ST_SHIFT) && !in_seq;

    life_bit_deserializer #(
        .N_CELLS (N_CELLS),
        .CNT_W   (CNT_W)
    ) u_deser (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .shift     (shift),
        .commit    (commit),
        .bit_in    (bus.cell_in),
        .idx       (bus.cnt_in),
        .snap_data (bus.snap_data),
        .snap_pop  (bus.snap_pop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            last_cnt     <= '0;
            snap_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            last_cnt  <= bus.cnt_in;
            overrun_q <= ovr_set | (overrun_q & ~bus.clear_err);
            seq_err_q <= seq_set | (seq_err_q & ~bus.clear_err);
            case (state)
                ST_IDLE: begin
                    if (bus.capture_req) begin
                        state  <= ST_ARM;
                        busy_q <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (at_zero) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!in_seq) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (at_last) begin
                        state        <= ST_HOLD;
                        busy_q       <= 1'b0;
                        snap_valid_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.snap_ready) begin
                        snap_valid_q <= 1'b0;
                        if (bus.capture_req) begin
                            state  <= ST_ARM;
                            busy_q <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    busy_q       <= 1'b0;
                    snap_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.snap_valid = snap_valid_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;
    assign bus.seq_err    = seq_err_q;

endmodule

// File: tb/tb_life_snapshot_reader.sv
// Bench: free-running column ring model driving the reader; snapshots checked against the ring pattern.
module tb_life_snapshot_reader;
    import life_snapshot_reader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    life_snapshot_reader_if bus();

    life_snapshot_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] ring_pat = '0;
    int          cnt_q    = 0;
    bit          skip_en  = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the ring one position; optionally drop index 18 to break continuity.
    task automatic tick();
        @(posedge clk);
        #1;
        if (skip_en && cnt_q == 17) begin
            cnt_q   = 19;
            skip_en = 1'b0;
        end else begin
            cnt_q = (cnt_q + 1) % 64;
        end
        bus.cnt_in  = 6'(cnt_q);
        bus.cell_in = ring_pat[cnt_q];
    endtask

    task automatic set_pattern(input logic [63:0] p);
        ring_pat    = p;
        bus.cell_in = ring_pat[cnt_q];
    endtask

    task automatic start_capture(input int start_idx);
        int n;
        n = 0;
        while (cnt_q != start_idx && n < 100) begin
            tick();
            n++;
        end
        bus.capture_req = 1'b1;
        tick();
        bus.capture_req = 1'b0;
        check_eq("arm_busy", bus.busy, 1'b1);
    endtask

    task automatic wait_zero();
        int n;
        n = 0;
        while (bus.cnt_in != 0 && n < 100) begin
            tick();
            n++;
        end
        check_eq("reach_cnt0", 64'(n < 100), 1'b1);
    endtask

    // Ring is now presenting index 0 to an armed reader: that is cycle 1.
    task automatic finish_capture(input logic [63:0] pat, input string tag);
        int n;
        wait_zero();
        n = 0;
        while (!bus.snap_valid && n < 200) begin
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, 64'(n), 64'd64);
        check_eq({tag, "_data"}, bus.snap_data, pat);
        check_eq({tag, "_pop"}, 64'(bus.snap_pop), 64'($countones(pat)));
    endtask

    task automatic handshake();
        bus.snap_ready = 1'b1;
        tick();
        bus.snap_ready = 1'b0;
        check_eq("hs_valid_low", bus.snap_valid, 1'b0);
        check_eq("hs_busy_low", bus.busy, 1'b0);
    endtask

    task automatic full_capture(input logic [63:0] pat, input int start_idx, input bit ready_hi, input string tag);
        set_pattern(pat);
        bus.snap_ready = ready_hi;
        start_capture(start_idx);
        finish_capture(pat, tag);
        handshake();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pat;
        logic [63:0] pat_b;
        bit          saw;

        bus.cell_in     = 1'b0;
        bus.cnt_in      = '0;
        bus.capture_req = 1'b0;
        bus.snap_ready  = 1'b0;
        bus.clear_err   = 1'b0;

        #2 rst_n = 1'b0;
        #20;
        check_eq("rst_valid", bus.snap_valid, 1'b0);
        check_eq("rst_data", bus.snap_data, 64'd0);
        check_eq("rst_pop", 64'(bus.snap_pop), 64'd0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_overrun", bus.overrun, 1'b0);
        check_eq("rst_seq_err", bus.seq_err, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        full_capture(64'hAAAA_AAAA_AAAA_AAAA, 10, 1'b0, "alt");
        full_capture(64'hFFFF_FFFF_FFFF_FFFF, int'($urandom_range(63, 0)), 1'b0, "ones");
        full_capture(64'h0, int'($urandom_range(63, 0)), 1'b0, "zeros");
        for (int i = 0; i < 6; i++) begin
            pat = {$urandom(), $urandom()};
            full_capture(pat, int'($urandom_range(63, 0)), 1'($urandom_range(1, 0)), "rand");
        end
        check_eq("flags_clean_ovr", bus.overrun, 1'b0);
        check_eq("flags_clean_seq", bus.seq_err, 1'b0);

        // Consumer stalls for 20 cycles; a request during the stall is an overrun.
        pat = {$urandom(), $urandom()};
        set_pattern(pat);
        start_capture(int'($urandom_range(63, 0)));
        finish_capture(pat, "stall");
        set_pattern(~pat);
        for (int i = 0; i < 20; i++) begin
            bus.capture_req = (i == 5);
            tick();
            check_eq("stall_data", bus.snap_data, pat);
            check_eq("stall_valid", bus.snap_valid, 1'b1);
        end
        bus.capture_req = 1'b0;
        check_eq("stall_overrun", bus.overrun, 1'b1);
        bus.clear_err   = 1'b1;
        bus.capture_req = 1'b1;
        tick();
        bus.capture_req = 1'b0;
        check_eq("clear_vs_set", bus.overrun, 1'b1);
        tick();
        bus.clear_err = 1'b0;
        check_eq("clear_overrun", bus.overrun, 1'b0);
        handshake();

        // Ring index jumps 17 -> 19 mid-capture.
        pat = {$urandom(), $urandom()};
        set_pattern(pat);
        start_capture(int'($urandom_range(63, 0)));
        wait_zero();
        skip_en = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.snap_valid) saw = 1'b1;
        end
        check_eq("skip_no_valid", saw, 1'b0);
        check_eq("skip_seq_err", bus.seq_err, 1'b1);
        check_eq("skip_idle", bus.busy, 1'b0);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        check_eq("seq_err_cleared", bus.seq_err, 1'b0);
        full_capture({$urandom(), $urandom()} | 64'h1, int'($urandom_range(63, 0)), 1'b0, "after_skip");

        // Reset lands at SHIFT index 30.
        pat = {$urandom(), $urandom()};
        set_pattern(pat);
        start_capture(int'($urandom_range(63, 0)));
        wait_zero();
        while (bus.cnt_in != 30) tick();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", bus.snap_valid, 1'b0);
        check_eq("mid_rst_data", bus.snap_data, 64'd0);
        check_eq("mid_rst_pop", 64'(bus.snap_pop), 64'd0);
        check_eq("mid_rst_busy", bus.busy, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.snap_valid || bus.busy) saw = 1'b1;
        end
        check_eq("post_rst_idle", saw, 1'b0);
        check_eq("post_rst_data", bus.snap_data, 64'd0);

        // Handshake and new request in the same HOLD cycle chain straight into ARM.
        pat   = {$urandom(), $urandom()};
        pat_b = {$urandom(), $urandom()};
        set_pattern(pat);
        start_capture(int'($urandom_range(63, 0)));
        finish_capture(pat, "chain_a");
        set_pattern(pat_b);
        bus.snap_ready  = 1'b1;
        bus.capture_req = 1'b1;
        tick();
        bus.snap_ready  = 1'b0;
        bus.capture_req = 1'b0;
        check_eq("chain_valid_low", bus.snap_valid, 1'b0);
        check_eq("chain_busy", bus.busy, 1'b1);
        check_eq("chain_overrun", bus.overrun, 1'b0);
        finish_capture(pat_b, "chain_b");
        handshake();
        check_eq("final_overrun", bus.overrun, 1'b0);
        check_eq("final_seq_err", bus.seq_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
